seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
Time-multiplexed driver for the 3-digit common-anode 7-segment display. Sits directly downstream of the binary-to-7-segment decoder and consumes its three active-low segment patterns (units, tens, hundreds). Drives one shared active-low segment bus and three active-low digit enables, scanning the digits in turn. Updates are double-buffered, applied only at frame boundaries, and every digit switch is separated by a blanking gap to prevent ghosting.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ 2.
BLANK_CYC, 500, cycles at the start of each slot with all digits off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
CNT_W, 16, width of the slot counter; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
seg0_in  in  7  units pattern, active-low segments {g..a}; 7'h7F = dark
seg1_in  in  7  tens pattern, same encoding
seg2_in  in  7  hundreds pattern, same encoding
load  in  1  single-cycle strobe; captures seg0_in..seg2_in into the pending buffer
en  in  1  scan enable
seg_out  out  7  shared segment bus, active-low
dig_sel_n  out  3  digit enables, active-low; bit0 = units, bit1 = tens, bit2 = hundreds
frame_done  out  1  one-cycle pulse on the last cycle of the hundreds slot

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - seg_out = 7'h7F, dig_sel_n = 3'b111, frame_done = 0.
  - Pending and active buffers = 7'h7F each; pending-valid flag = 0.
  - Slot counter = 0; digit index = 0; state = BLANK.
- State machine per slot:
  - BLANK: runs for BLANK_CYC cycles with outputs dark, then goes to SHOW.
  - SHOW: runs for the remaining SCAN_DIV - BLANK_CYC cycles.
  - On the last SHOW cycle the digit index advances 0→1→2→0 and the state returns to BLANK.
  - If BLANK_CYC = 0, BLANK is skipped.
- Outputs are registered:
  - In SHOW: seg_out = active[idx]; dig_sel_n has only bit idx low.
  - In BLANK: seg_out = 7'h7F, dig_sel_n = 3'b111.
- Slot counter counts 0..SCAN_DIV-1 and wraps to 0.
- frame_done = 1 exactly on the cycle where idx = 2 and counter = SCAN_DIV-1.
- Frame period is 3*SCAN_DIV cycles.
- Load and buffering:
  - load = 1 writes all three inputs into the pending buffer and sets pending-valid.
  - Multiple loads within a frame: the last one wins.
  - At the frame boundary (the cycle frame_done = 1), pending is copied to active if pending-valid, and pending-valid clears. The new data is first visible in the next units slot.
  - load coincident with the frame boundary: the inputs presented that cycle go straight to active (bypass), and pending-valid ends at 0.
- Enable:
  - en = 0 forces state BLANK, counter = 0, idx = 0 and dark outputs; frame_done = 0.
  - While en = 0, a load is copied to active immediately.
  - When en rises, scanning starts with a units BLANK slot on the following cycle.
- A partial frame is never shown with a mix of old and new data.
- Reset mid-frame returns everything to the reset values immediately, with no glitch on dig_sel_n: the outputs are driven from flops that reset to dark.

Decomposition:
- Package seg_pkg:
  - SEG_OFF = 7'h7F, DIG_NONE = 3'b111, NUM_DIGITS = 3.
  - Glyph constants SEG_0..SEG_9.
  - State enum {BLANK, SHOW}.
- Sub-module seg_slot_timer (parameters SCAN_DIV, BLANK_CYC, CNT_W):
  - Prescaler counter with en and clear.
  - Outputs in_blank, slot_last, cnt.
  - The top level holds the digit index, buffers and output registers.

Test Plan (SCAN_DIV = 8, BLANK_CYC = 2):
- Reset, then en = 1 with no load → seg_out stays 7'h7F throughout. dig_sel_n sequence per frame: 111×2, 110×6, 111×2, 101×6, 111×2, 011×6. frame_done pulses every 24 cycles.
- load with seg0 = 7'h40, seg1 = 7'h79, seg2 = 7'h24 at cycle 5 of frame → the current frame stays dark; from the next frame, units slot shows 7'h40, tens 7'h79, hundreds 7'h24.
- Two loads in one frame (7'h40 then 7'h12 on seg0) → only 7'h12 appears next frame; 7'h40 is never driven.
- load asserted on the frame_done cycle with seg0 = 7'h30 → 7'h30 is shown in the immediately following units slot.
- en dropped mid tens-slot → the next cycle outputs are 7'h7F/111. When en is re-raised, the first two cycles are 111, then 110.
- rst_n pulsed low mid SHOW → outputs go to 7'h7F/111 asynchronously and the buffers read dark afterwards.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the 3-digit multiplexed 7-segment driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; digit enables are active-low,
// with bit0 = units, bit1 = tens and bit2 = hundreds.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 3;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [2:0] DIG_NONE = 3'b111;

    // Active-low decimal glyphs
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // One 7-bit pattern per digit; element 0 is the units digit
    typedef logic [NUM_DIGITS-1:0][6:0] seg_vec_t;

    typedef enum logic {
        BLANK,
        SHOW
    } slot_state_e;

    // Active-low one-hot digit enable for a digit index
    function automatic logic [2:0] dig_sel_n_f(input logic [1:0] idx);
        logic [2:0] sel;
        sel = 3'b000;
        sel[idx] = 1'b1;
        return ~sel;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus bundle for seg_scan_driver.
//   seg0_in/seg1_in/seg2_in : units/tens/hundreds patterns from the decoder
//   load                    : single-cycle strobe capturing the three patterns
//   en                      : scan enable
//   seg_out                 : shared active-low segment bus
//   dig_sel_n               : active-low digit enables
//   frame_done              : pulse on the last cycle of the hundreds slot
// master = pattern source / controller, slave = the driver.
interface seg_scan_driver_if;

    logic [6:0] seg0_in;
    logic [6:0] seg1_in;
    logic [6:0] seg2_in;
    logic       load;
    logic       en;
    logic [6:0] seg_out;
    logic [2:0] dig_sel_n;
    logic       frame_done;

    modport master (
        output seg0_in,
        output seg1_in,
        output seg2_in,
        output load,
        output en,
        input  seg_out,
        input  dig_sel_n,
        input  frame_done
    );

    modport slave (
        input  seg0_in,
        input  seg1_in,
        input  seg2_in,
        input  load,
        input  en,
        output seg_out,
        output dig_sel_n,
        output frame_done
    );

endinterface

// File: rtl/seg_slot_timer.sv
// Per-digit slot timer: a 0..SCAN_DIV-1 prescaler plus a BLANK/SHOW phase FSM.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en_i          : advance the counter
//   clr_i         : synchronous clear to counter 0 / BLANK (wins over en_i)
//   cnt_o         : current slot counter
//   in_blank_o    : current cycle lies in the blanking gap
//   slot_last_o   : current cycle is the last cycle of the slot
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             in_blank_o,
    output logic             slot_last_o
);

    localparam int unsigned BLANK_LAST = (BLANK_CYC == 0) ? 0 : BLANK_CYC - 1;

    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blank_last;

    assign slot_last_o = (cnt_q == CNT_W'(SCAN_DIV - 1));
    // With no blanking gap the BLANK state (reset/clear value) behaves as a SHOW cycle
    assign blank_last  = (BLANK_CYC == 0) || (cnt_q == CNT_W'(BLANK_LAST));
    assign in_blank_o  = (state_q == BLANK) && (BLANK_CYC != 0);
    assign cnt_o       = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = BLANK;
            cnt_d   = '0;
        end else if (en_i) begin
            cnt_d = slot_last_o ? '0 : cnt_q + CNT_W'(1);
            unique case (state_q)
                BLANK: if (blank_last) state_d = SHOW;
                SHOW:  if (slot_last_o) state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                default: state_d = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 3-digit common-anode 7-segment display.
// Double-buffers the decoder's three patterns, commits them only at frame
// boundaries, and scans units -> tens -> hundreds with a dark gap at the start
// of each slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_scan_driver_if.slave (pattern inputs, load, en, display outputs)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_driver_if.slave    bus
);

    logic [CNT_W-1:0] cnt;
    logic             in_blank;
    logic             slot_last;

    logic [1:0] idx_q, idx_d;
    seg_vec_t   pend_q, pend_d;
    seg_vec_t   act_q, act_d;
    logic       pend_vld_q, pend_vld_d;
    logic [6:0] seg_q, seg_d;
    logic [2:0] dig_q, dig_d;
    logic       fd_q, fd_d;
    seg_vec_t   in_vec;

    seg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (bus.en),
        .clr_i       (!bus.en),
        .cnt_o       (cnt),
        .in_blank_o  (in_blank),
        .slot_last_o (slot_last)
    );

    assign in_vec = {bus.seg2_in, bus.seg1_in, bus.seg0_in};

    // The timer and digit index run one cycle ahead of the output flops: the
    // registered outputs in cycle n reflect the timer state of cycle n-1. The
    // cycle with fd_q high is therefore the frame boundary, and the first
    // units cycle is computed in that same cycle from act_d, so freshly
    // committed data reaches the display without a stale cycle.
    always_comb begin
        idx_d = idx_q;
        if (!bus.en) begin
            idx_d = 2'd0;
        end else if (slot_last) begin
            idx_d = (idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_comb begin
        pend_d     = pend_q;
        act_d      = act_q;
        pend_vld_d = pend_vld_q;
        if (bus.load && (!bus.en || fd_q)) begin
            // Boundary or idle: nothing partial on screen, so go straight to active
            act_d      = in_vec;
            pend_vld_d = 1'b0;
        end else if (fd_q && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pend_d     = in_vec;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_NONE;
        fd_d  = 1'b0;
        if (bus.en) begin
            if (!in_blank) begin
                seg_d = act_d[idx_q];
                dig_d = dig_sel_n_f(idx_q);
            end
            fd_d = (idx_q == 2'(NUM_DIGITS - 1)) && (cnt == CNT_W'(SCAN_DIV - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= 2'd0;
            pend_q     <= {NUM_DIGITS{SEG_OFF}};
            act_q      <= {NUM_DIGITS{SEG_OFF}};
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_NONE;
            fd_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_sel_n  = dig_q;
    assign bus.frame_done = fd_q;

endmodule
